multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for a multi-cycle RV64 subset (R-type, addi, ld, sd, beq)
// with a memory-wait watchdog, a sticky fault/halt state and a retired-instruction counter.
`timescale 1ns/1ps
module multicycle_control_fsm #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WR = 4'd4;
    localparam logic [3:0] S_WB_MEM = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_WB_ALU = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    localparam int              WAIT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    logic [3:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic [1:0]        r_fault;

    logic [3:0] w_state_next;
    logic [1:0] w_fault_set;
    logic       w_retire;
    logic       w_timeout;
    logic       w_mem_state;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready arriving on the last allowed cycle wins over the timeout.
    assign w_timeout   = !mem_ready && (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_fault   <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_wait <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            if ((w_fault_set != 2'b00) && (r_fault == 2'b00))
                r_fault <= w_fault_set;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fault_set  = 2'b00;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                    w_fault_set  = F_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         w_state_next = S_EXEC_R;
                    OP_I:         w_state_next = S_EXEC_I;
                    OP_LD, OP_SD: w_state_next = S_ADDR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    default: begin
                        w_state_next = S_HALT;
                        w_fault_set  = F_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_state_next = S_WB_ALU;
            S_ADDR:   w_state_next = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_state_next = S_WB_MEM;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                    w_fault_set  = F_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                    w_fault_set  = F_TIMEOUT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_HALT: w_state_next = S_HALT;
            default: begin
                w_state_next = S_HALT;
                w_fault_set  = F_ILLEGAL;
            end
        endcase
    end

    // Everything, including the debug state and counters, reads as zero while reset is held.
    always_comb begin
        pc_en      = 1'b0;
        pc_source  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        fault      = 2'b00;
        retired    = '0;
        state      = 4'd0;
        if (!reset) begin
            halted  = (r_state == S_HALT);
            fault   = r_fault;
            retired = r_retired;
            state   = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_ADDR, S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_source = 1'b1;
                    pc_en     = zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle state/control sequence and checks every cycle.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam int CNT_W      = 2;
    localparam int WAIT_LIMIT = 4;

    localparam int FETCH = 0, DECODE = 1, ADDR = 2, MEM_RD = 3, MEM_WR = 4, WB_MEM = 5;
    localparam int EXEC_R = 6, EXEC_I = 7, WB_ALU = 8, BRANCH = 9, HALT = 15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_write, halted;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, fault;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;
    logic [13:0]      w_ctrl;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int m_ret    = 0;
    int m_fault  = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .halted(halted), .fault(fault), .retired(retired), .state(state)
    );

    assign w_ctrl = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
    endfunction

    // Control outputs per state as tabulated for the controller.
    function automatic logic [13:0] exp_ctrl(input int st, input logic rdy, input logic z);
        logic pe, ps, iod, mr, mw, irw, m2r, rw;
        logic [1:0] a, b, op;
        pe = 0; ps = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rw = 0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            FETCH:  begin mr = 1; b = 2'b01; pe = rdy; irw = rdy; end
            DECODE: begin a = 2'b01; b = 2'b10; end
            ADDR, EXEC_I: begin a = 2'b10; b = 2'b10; end
            MEM_RD: begin iod = 1; mr = 1; end
            MEM_WR: begin iod = 1; mw = 1; end
            WB_MEM: begin m2r = 1; rw = 1; end
            EXEC_R: begin a = 2'b10; op = 2'b10; end
            WB_ALU: rw = 1;
            BRANCH: begin a = 2'b10; op = 2'b01; ps = 1; pe = z; end
            default: ;
        endcase
        return {pe, ps, iod, mr, mw, irw, m2r, rw, a, b, op};
    endfunction

    task automatic cycle(input int st, input logic rdy, input logic [6:0] op, input logic z);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        #1;
        check_val("state", 32'(state), 32'(st));
        check_val("ctrl", 32'(w_ctrl), 32'(exp_ctrl(st, rdy, z)));
        check_val("halted", 32'(halted), 32'(st == HALT));
        check_val("fault", 32'(fault), 32'(m_fault));
        check_val("retired", 32'(retired), 32'(m_ret));
        $display("cyc=%0d st=%0d rdy=%0b op=%07b z=%0b ctrl=%014b ret=%0d flt=%0d",
                 cyc_n, state, rdy, op, z, w_ctrl, retired, fault);
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = rb();
        opcode    = ro();
        #1;
        check_val("rst_outputs", 32'({state, w_ctrl, halted, fault, retired}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_hold", 32'({state, w_ctrl, halted, fault, retired}), 32'd0);
        cyc_n++;
        reset   = 1'b0;
        m_ret   = 0;
        m_fault = 0;
    endtask

    task automatic do_fetch(input int fw);
        for (int i = 0; i < fw; i++) cycle(FETCH, 1'b0, ro(), rb());
        cycle(FETCH, 1'b1, ro(), rb());
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        do_fetch(fw);
        cycle(DECODE, rb(), op, rb());
        case (op)
            OP_R: begin
                cycle(EXEC_R, rb(), ro(), rb());
                cycle(WB_ALU, rb(), ro(), rb());
            end
            OP_I: begin
                cycle(EXEC_I, rb(), ro(), rb());
                cycle(WB_ALU, rb(), ro(), rb());
            end
            OP_LD: begin
                cycle(ADDR, rb(), op, rb());
                for (int i = 0; i < mw; i++) cycle(MEM_RD, 1'b0, ro(), rb());
                cycle(MEM_RD, 1'b1, ro(), rb());
                cycle(WB_MEM, rb(), ro(), rb());
            end
            OP_SD: begin
                cycle(ADDR, rb(), op, rb());
                for (int i = 0; i < mw; i++) cycle(MEM_WR, 1'b0, ro(), rb());
                cycle(MEM_WR, 1'b1, ro(), rb());
            end
            default: cycle(BRANCH, rb(), ro(), z);
        endcase
        m_ret = (m_ret + 1) % (1 << CNT_W);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(HALT, (i == 1) ? 1'b1 : rb(), ro(), rb());
    endtask

    task automatic run_illegal(input logic [6:0] op, input int fw);
        do_fetch(fw);
        cycle(DECODE, rb(), op, rb());
        m_fault = 1;
        halt_cycles(4);
    endtask

    // which: 0 = stall in FETCH, 1 = stall in MEM_RD, 2 = stall in MEM_WR
    task automatic run_timeout(input int which);
        int st;
        if (which == 0) begin
            st = FETCH;
        end else begin
            st = (which == 1) ? MEM_RD : MEM_WR;
            do_fetch(0);
            cycle(DECODE, rb(), (which == 1) ? OP_LD : OP_SD, rb());
            cycle(ADDR, rb(), (which == 1) ? OP_LD : OP_SD, rb());
        end
        for (int i = 0; i < WAIT_LIMIT; i++) cycle(st, 1'b0, ro(), rb());
        m_fault = 2;
        halt_cycles(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [6:0] bad;
        logic [6:0] legal_ops [5];
        legal_ops[0] = OP_R; legal_ops[1] = OP_I; legal_ops[2] = OP_LD;
        legal_ops[3] = OP_SD; legal_ops[4] = OP_BEQ;

        do_reset();
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_LD, 1'b0, 0, 3);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);

        do_reset();
        run_instr(OP_I, 1'b0, 1, 0);
        run_illegal(7'b1111111, 0);
        do_reset();
        run_timeout(0);
        do_reset();
        run_instr(OP_R, 1'b0, WAIT_LIMIT - 1, 0);
        run_timeout(1);
        do_reset();
        run_instr(OP_SD, 1'b0, 0, WAIT_LIMIT - 1);
        run_timeout(2);

        // Reset in the middle of a store, then five stores with a 2-bit counter.
        do_reset();
        do_fetch(0);
        cycle(DECODE, rb(), OP_SD, rb());
        cycle(ADDR, rb(), OP_SD, rb());
        cycle(MEM_WR, 1'b0, ro(), rb());
        do_reset();
        run_instr(OP_SD, 1'b0, WAIT_LIMIT - 1, 0);
        for (int i = 0; i < 4; i++) run_instr(OP_SD, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        #1;
        check_val("retired_wrap", 32'(retired), 32'd1);

        do_reset();
        for (int n = 0; n < 60; n++) begin
            run_instr(legal_ops[$urandom_range(0, 4)], rb(),
                      $urandom_range(0, WAIT_LIMIT - 1), $urandom_range(0, WAIT_LIMIT - 1));
        end
        do
            bad = 7'($urandom);
        while (is_legal(bad));
        run_illegal(bad, $urandom_range(0, WAIT_LIMIT - 1));
        do_reset();
        run_instr(OP_BEQ, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
